// File: rtl/branch_pc_sequencer_if.sv
// Decode-side bundle for branch_pc_sequencer: control, branch operands and PC/flush outputs.
// slave = the sequencer, master = whoever drives decode (ID stage or bench).
interface branch_pc_sequencer_if #(
   parameter int CANT_BITS_ADDR                     = 11,
   parameter int CANT_BITS_IMMEDIATE                = 16,
   parameter int CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
   parameter int CANT_BITS_FLAG_BRANCH              = 3,
   parameter int CANT_BITS_REGISTROS                = 32,
   parameter int CANT_BITS_CONTADOR                 = 16
);
   logic                                          i_start;
   logic                                          i_stall;
   logic                                          i_halt;
   logic [CANT_BITS_FLAG_BRANCH-1:0]              i_flag_branch;
   logic [CANT_BITS_IMMEDIATE-1:0]                i_immediate_address;
   logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] i_instruction_index_branch;
   logic [CANT_BITS_REGISTROS-1:0]                i_data_rs;
   logic [CANT_BITS_REGISTROS-1:0]                i_data_rt;
   logic                                          i_operands_ready;
   logic [CANT_BITS_ADDR-1:0]                     o_pc;
   logic [CANT_BITS_ADDR-1:0]                     o_pc_link;
   logic                                          o_link_write;
   logic                                          o_flush;
   logic                                          o_fetch_enable;
   logic                                          o_halted;
   logic [CANT_BITS_CONTADOR-1:0]                 o_cnt_taken;
   logic [CANT_BITS_CONTADOR-1:0]                 o_cnt_not_taken;

   modport slave (
      input  i_start, i_stall, i_halt, i_flag_branch, i_immediate_address,
             i_instruction_index_branch, i_data_rs, i_data_rt, i_operands_ready,
      output o_pc, o_pc_link, o_link_write, o_flush, o_fetch_enable, o_halted,
             o_cnt_taken, o_cnt_not_taken
   );

   modport master (
      output i_start, i_stall, i_halt, i_flag_branch, i_immediate_address,
             i_instruction_index_branch, i_data_rs, i_data_rt, i_operands_ready,
      input  o_pc, o_pc_link, o_link_write, o_flush, o_fetch_enable, o_halted,
             o_cnt_taken, o_cnt_not_taken
   );
endinterface

// File: rtl/branch_pc_sequencer.sv
// PC owner / ID-stage next-PC sequencer: branch decision is combinational, PC loads at the edge, flush/link pulse the cycle after.
// Stall, halt and operand-wait hold the PC with fetch disabled. BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_pc_sequencer #(
   parameter int CANT_BITS_ADDR                     = 11,
   parameter int CANT_BITS_IMMEDIATE                = 16,
   parameter int CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
   parameter int CANT_BITS_FLAG_BRANCH              = 3,
   parameter int CANT_BITS_REGISTROS                = 32,
   parameter int CANT_BITS_CONTADOR                 = 16
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   branch_pc_sequencer_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_HALT = 2'b10;

   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_NONE = 'd0;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_BEQ  = 'd1;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_BNE  = 'd2;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_J    = 'd3;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_JAL  = 'd4;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_JR   = 'd5;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_JALR = 'd6;
   localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FB_NOP7 = 'd7;

   logic [1:0]                       r_state;
   logic [CANT_BITS_ADDR-1:0]        r_pc;
   logic [CANT_BITS_ADDR-1:0]        r_pc_link;
   logic                             r_flush;
   logic                             r_link_write;

   logic [CANT_BITS_FLAG_BRANCH-1:0] w_kind;
   logic                             w_needs_ops;
   logic                             w_wait;
   logic                             w_advance;
   logic                             w_taken;
   logic                             w_link;
   logic                             w_resolved;
   logic [CANT_BITS_ADDR-1:0]        w_target;
   logic [CANT_BITS_ADDR-1:0]        w_pc_next;

   // The instruction in ID during a flush cycle is being killed, so its branch code is masked.
   // r_pc is already pc_id+1; adding the raw low offset bits mod 2^ADDR equals the sign-extended add.
   always_comb begin
      w_kind      = r_flush ? FB_NONE : bus.i_flag_branch;
      w_needs_ops = (w_kind == FB_BEQ) || (w_kind == FB_BNE) ||
                    (w_kind == FB_JR)  || (w_kind == FB_JALR);
      w_wait      = w_needs_ops && !bus.i_operands_ready;
      w_advance   = !i_reset && (r_state == ST_RUN) && !bus.i_halt && !bus.i_stall && !w_wait;
      w_resolved  = (w_kind != FB_NONE) && (w_kind != FB_NOP7);
      w_taken     = 1'b0;
      w_link      = 1'b0;
      w_target    = r_pc + bus.i_immediate_address[CANT_BITS_ADDR-1:0];
      case (w_kind)
         FB_BEQ:  w_taken = (bus.i_data_rs == bus.i_data_rt);
         FB_BNE:  w_taken = (bus.i_data_rs != bus.i_data_rt);
         FB_J: begin
            w_taken  = 1'b1;
            w_target = bus.i_instruction_index_branch[CANT_BITS_ADDR-1:0];
         end
         FB_JAL: begin
            w_taken  = 1'b1;
            w_link   = 1'b1;
            w_target = bus.i_instruction_index_branch[CANT_BITS_ADDR-1:0];
         end
         FB_JR: begin
            w_taken  = 1'b1;
            w_target = bus.i_data_rs[CANT_BITS_ADDR-1:0];
         end
         FB_JALR: begin
            w_taken  = 1'b1;
            w_link   = 1'b1;
            w_target = bus.i_data_rs[CANT_BITS_ADDR-1:0];
         end
         default: ;
      endcase
      w_pc_next = w_taken ? w_target : r_pc + 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= '0;
         r_pc_link    <= '0;
         r_flush      <= 1'b0;
         r_link_write <= 1'b0;
      end else begin
         r_flush      <= 1'b0;
         r_link_write <= 1'b0;
         case (r_state)
            ST_IDLE: if (bus.i_start) r_state <= ST_RUN;
            ST_RUN: begin
               if (bus.i_halt) begin
                  r_state <= ST_HALT;
               end else if (w_advance) begin
                  r_pc    <= w_pc_next;
                  r_flush <= w_taken;
                  if (w_taken && w_link) begin
                     r_link_write <= 1'b1;
                     r_pc_link    <= r_pc;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_pc           = r_pc;
   assign bus.o_pc_link      = r_pc_link;
   assign bus.o_link_write   = r_link_write;
   assign bus.o_flush        = r_flush;
   assign bus.o_fetch_enable = w_advance;
   assign bus.o_halted       = (r_state == ST_HALT);

`ifdef BRANCH_STATS_EN
   logic [CANT_BITS_CONTADOR-1:0] r_cnt_taken;
   logic [CANT_BITS_CONTADOR-1:0] r_cnt_not_taken;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt_taken     <= '0;
         r_cnt_not_taken <= '0;
      end else if (w_advance && w_resolved) begin
         if (w_taken) begin
            if (r_cnt_taken != '1) r_cnt_taken <= r_cnt_taken + 1'b1;
         end else begin
            if (r_cnt_not_taken != '1) r_cnt_not_taken <= r_cnt_not_taken + 1'b1;
         end
      end
   end

   assign bus.o_cnt_taken     = r_cnt_taken;
   assign bus.o_cnt_not_taken = r_cnt_not_taken;
`else
   assign bus.o_cnt_taken     = '0;
   assign bus.o_cnt_not_taken = '0;
`endif

   // Upper operand bits do not reach the narrow PC.
   logic w_unused;
   assign w_unused = ^{bus.i_immediate_address[CANT_BITS_IMMEDIATE-1:CANT_BITS_ADDR],
                       bus.i_instruction_index_branch[CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:CANT_BITS_ADDR],
                       w_resolved};
endmodule
